// File: rtl/store_pulse_debouncer_if.sv
// Button/switch input bundle and the store/data pair it produces for the
// one-bit storage register. master = stimulus side, slave = debouncer side.
interface store_pulse_debouncer_if;
  logic btn_raw;
  logic sw_raw;
  logic store;
  logic data;
  logic pressed;

  modport master (
    output btn_raw,
    output sw_raw,
    input  store,
    input  data,
    input  pressed
  );

  modport slave (
    input  btn_raw,
    input  sw_raw,
    output store,
    output data,
    output pressed
  );
endinterface

// File: rtl/store_pulse_debouncer.sv
// Input-conditioning stage for the board's one-bit storage register.
// Synchronizes a raw push-button and slide switch into clk, debounces the
// button, and on each accepted press emits a one-cycle store pulse together
// with the switch value captured at that moment.
module store_pulse_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  store_pulse_debouncer_if.slave  bus
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // Terminal count: a level is accepted once cnt reaches this value while the
  // synchronized button still agrees. DEBOUNCE_CYCLES <= 2**CNT_W keeps it in range.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             b1;
  logic             btn_s;
  logic             s1;
  logic             sw_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             store_q;
  logic             data_q;
  logic             pressed_q;

  // Two-flop synchronizers for the asynchronous button and switch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b1    <= 1'b0;
      btn_s <= 1'b0;
      s1    <= 1'b0;
      sw_s  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous
      // stage's old value, so the chain really is two registers deep.
      b1    <= bus.btn_raw;
      btn_s <= b1;
      s1    <= bus.sw_raw;
      sw_s  <= s1;
    end
  end

  // Debounce FSM with registered store/data/pressed outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RELEASED;
      cnt       <= '0;
      store_q   <= 1'b0;
      data_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      // store is a pulse: low unless the acceptance branch below raises it.
      store_q <= 1'b0;
      case (state)
        RELEASED: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= RELEASED;
          end else if (cnt == CNT_MAX) begin
            state     <= HELD;
            store_q   <= 1'b1;
            data_q    <= sw_s;
            pressed_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            state     <= RELEASED;
            pressed_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= RELEASED;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.store   = store_q;
  assign bus.data    = data_q;
  assign bus.pressed = pressed_q;

endmodule

// File: doc/store_pulse_debouncer.md
Name: store_pulse_debouncer

Overview:
Input-conditioning stage that sits directly upstream of the one-bit storage register on the FPGA board. It synchronizes a raw push-button and a raw slide switch into the clk domain and debounces the button. On each debounced press it emits a single-cycle store pulse together with a stable data bit, which drive the register's store and data inputs.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); legal range 1..2**CNT_W.
CNT_W, 20, debounce counter width.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
btn_raw  input  1  raw, bouncy, asynchronous push-button; 1 = pressed
sw_raw  input  1  raw asynchronous slide switch carrying the value to store
store  output  1  one-cycle pulse per accepted press; drives register store
data  output  1  switch value captured at the press; drives register data
pressed  output  1  debounced button level (1 in HELD and RELEASE_WAIT)

Behaviour:
- Reset: rst low asynchronously clears all state. Synchronizer flops = 0, state = RELEASED, counter = 0, store = 0, data = 0, pressed = 0. Clearing takes effect immediately, not at the next clock.
- Synchronizers: two-flop chains btn_raw -> b1 -> btn_s and sw_raw -> s1 -> sw_s. The FSM and the capture logic use only btn_s and sw_s.
- FSM states: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
  - RELEASED: if btn_s = 1, go to PRESS_WAIT and set cnt = 0.
  - PRESS_WAIT: if btn_s = 0, go to RELEASED (bounce rejected, no pulse). Else if cnt = DEBOUNCE_CYCLES-1, go to HELD, set store <= 1 and data <= sw_s. Else cnt++.
  - HELD: if btn_s = 0, go to RELEASE_WAIT and set cnt = 0.
  - RELEASE_WAIT: if btn_s = 1, go to HELD (bounce, no pulse). Else if cnt = DEBOUNCE_CYCLES-1, go to RELEASED. Else cnt++.
- store: registered output, high for exactly one cycle per accepted press and 0 in all other cycles. A press held indefinitely produces one pulse only.
- data: updates only on the edge where store rises. It holds that value until the next accepted press or reset, so it is stable for the whole cycle in which store = 1.
- pressed: registered, 1 exactly while state is HELD or RELEASE_WAIT.
- Latency:
  - btn_raw first sampled high at edge 0 and held high: store is high from edge N+2 to edge N+3, where N = DEBOUNCE_CYCLES.
  - data captures sw_s, i.e. sw_raw as sampled two edges earlier.
- Counter: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps. With DEBOUNCE_CYCLES = 1, a press is accepted on the first PRESS_WAIT edge.
- Bounce: any drop of btn_s during PRESS_WAIT restarts qualification from RELEASED. Any rise of btn_s during RELEASE_WAIT returns to HELD. Neither case emits a pulse.
- Switch changes during HELD, or while no press is in progress, have no effect on data.
- Reset mid-operation: store drops at once. After rst returns high, a button still held is treated as a fresh press and yields exactly one store after full qualification.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: rst = 0 with btn_raw = 1 and sw_raw = 1 toggling -> store = 0, data = 0, pressed = 0 throughout; outputs clear without any clock edge.
- Clean press: sw_raw = 1, btn_raw rises before edge 0 and is held 20 cycles -> store = 1 only between edges 6 and 7, data = 1 from edge 6, pressed = 1 from edge 6; no further pulses.
- Bounce reject: btn_raw pattern 1,1,0,1,1,1,0 (one value per cycle), then 0 -> store is never 1, pressed stays 0, state returns to RELEASED.
- Release bounce: after an accepted press, btn_raw goes 0 for 2 cycles, back to 1, then is held 10 cycles -> no second store pulse; pressed stays 1.
- Two presses: press with sw_raw = 1, full release, then press with sw_raw = 0 -> two single-cycle store pulses; data = 1 after the first pulse and 0 after the second. Toggling sw_raw between presses leaves data unchanged.
- Reset mid-qualification: assert rst during PRESS_WAIT with cnt = 2, release rst with the button held -> no pulse during reset; exactly one pulse N+2 edges after btn_raw is first resampled high (first edge after rst release = edge 0).
